// File: rtl/spram_req_pkg.sv
// Shared state encoding and index normalisation for the single-port RAM requester.
package spram_req_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_RESP    = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      CAPTURE = ST_CAPTURE,
      RESP    = ST_RESP
   } state_t;

   typedef struct packed {
      logic        ok;
      logic [31:0] eff;
   } norm_t;

   // Negative indices count back from the end of the list; the caller truncates eff to its address width.
   function automatic norm_t normalize_idx(input logic signed [31:0] idx, input int length);
      norm_t r;
      r.ok  = 1'b0;
      r.eff = '0;
      if (idx >= 0) begin
         r.ok  = (idx < length);
         r.eff = idx;
      end else begin
         r.ok  = (idx >= -length);
         r.eff = idx + length;
      end
      return r;
   endfunction

endpackage

// File: rtl/spram_index_norm.sv
// Combinational signed-index normaliser with range check against the list length.
module spram_index_norm
   import spram_req_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int RAM_LENGTH = 10
) (
   input  logic [ADDR_WIDTH-1:0] idx,
   output logic                  ok,
   output logic [ADDR_WIDTH-1:0] eff
);

   logic signed [31:0] idx_sext;
   norm_t              norm;
   logic               unused_eff_hi;

   assign idx_sext      = 32'(signed'(idx));
   assign norm          = normalize_idx(idx_sext, RAM_LENGTH);
   assign ok            = norm.ok;
   // Upper bits only matter modulo 2**ADDR_WIDTH, so they are dropped here.
   assign eff           = norm.eff[ADDR_WIDTH-1:0];
   assign unused_eff_hi = ^norm.eff[31:ADDR_WIDTH];

endmodule

// File: rtl/spram_requester.sv
// Serialises client read/write requests onto a single-port RAM with 1-cycle registered read.
module spram_requester
   import spram_req_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int RAM_LENGTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_idx,
   input  logic [DATA_WIDTH-1:0] req_d,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_q,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_d,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   state_t                  state, state_nxt;
   logic                    idx_ok;
   logic [ADDR_WIDTH-1:0]   idx_eff;
   logic [ADDR_WIDTH-1:0]   addr_hold;
   logic [DATA_WIDTH-1:0]   q_reg, q_nxt;
   logic                    err_reg, err_nxt;
   logic                    accept;

   spram_index_norm #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RAM_LENGTH (RAM_LENGTH)
   ) u_norm (
      .idx (req_idx),
      .ok  (idx_ok),
      .eff (idx_eff)
   );

   always_comb begin
      state_nxt = state;
      q_nxt     = q_reg;
      err_nxt   = err_reg;
      accept    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = addr_hold;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept   = 1'b1;
               ram_addr = idx_eff;
               q_nxt    = '0;
               err_nxt  = !idx_ok;
               if (!idx_ok) begin
                  state_nxt = RESP;
               end else if (req_we) begin
                  ram_we    = 1'b1;
                  state_nxt = RESP;
               end else begin
                  state_nxt = CAPTURE;
               end
            end
         end
         // RAM has registered the address at the accept edge; its Q is valid now.
         CAPTURE: begin
            q_nxt     = ram_q;
            err_nxt   = 1'b0;
            state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         q_reg     <= '0;
         err_reg   <= 1'b0;
         addr_hold <= '0;
      end else begin
         state   <= state_nxt;
         q_reg   <= q_nxt;
         err_reg <= err_nxt;
         if (accept) addr_hold <= idx_eff;
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_q     = q_reg;
   assign resp_err   = err_reg;
   assign ram_d      = req_d;

endmodule

// File: tb/tb_spram_requester.sv
// Bench for spram_requester: list-level reference model checked every cycle plus directed literal checks.
module tb_spram_requester;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [4:0] req_idx = '0;
   logic [7:0] req_d = '0;
   logic       resp_valid;
   logic       resp_ready = 1'b0;
   logic [7:0] resp_q;
   logic       resp_err;
   logic [4:0] ram_addr;
   logic [7:0] ram_d;
   logic       ram_we;
   logic [7:0] ram_q = '0;

   int total = 0;
   int bad   = 0;

   spram_requester #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .RAM_LENGTH(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_idx    (req_idx),
      .req_d      (req_d),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_q     (resp_q),
      .resp_err   (resp_err),
      .ram_addr   (ram_addr),
      .ram_d      (ram_d),
      .ram_we     (ram_we),
      .ram_q      (ram_q)
   );

   always #5 clk = ~clk;

   // SinglePortRam behaviour: write on WE, Q registers mem[addr] every edge.
   logic [7:0] mem [32] = '{default: 8'h00};
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_d;
      ram_q <= mem[ram_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Python-style list indexing on a 10-entry list, addresses wrap modulo 32.
   task automatic norm(input logic [4:0] idx, output logic ok, output logic [4:0] eff);
      int s;
      s = int'(idx);
      if (s >= 16) s = s - 32;
      ok = (s < 10) && (s >= -10);
      if (s < 0) s = s + 10;
      eff = 5'(s & 31);
   endtask

   // Reference model: one outstanding op, response after 1 (write/error) or 2 (read) cycles.
   logic [7:0] ref_mem [10] = '{default: 8'h00};
   bit         m_busy = 1'b0;
   int         m_wait = 0;
   logic [7:0] m_q = '0;
   logic       m_err = 1'b0;
   logic [4:0] m_eff = '0;

   always @(negedge clk) begin
      logic       ok;
      logic [4:0] eff;
      logic       acc;
      if (!rst) begin
         chk("rst_resp_valid", resp_valid, 1'b0);
         chk("rst_ram_we", ram_we, 1'b0);
         m_busy = 1'b0;
         m_wait = 0;
      end else begin
         chk("req_ready", req_ready, !m_busy);
         chk("resp_valid", resp_valid, m_busy && m_wait == 0);
         if (m_busy && m_wait == 0) begin
            chk("resp_q", resp_q, m_q);
            chk("resp_err", resp_err, m_err);
         end
         if (m_busy && m_wait == 1) chk("capture_addr", ram_addr, m_eff);
         acc = !m_busy && req_valid;
         norm(req_idx, ok, eff);
         chk("ram_we", ram_we, acc && req_we && ok);
         if (acc) chk("accept_addr", ram_addr, eff);
         if (acc && req_we && ok) chk("ram_d", ram_d, req_d);
         if (acc) begin
            m_busy = 1'b1;
            m_eff  = eff;
            m_err  = !ok;
            m_q    = '0;
            m_wait = 0;
            if (ok && req_we) ref_mem[eff] = req_d;
            if (ok && !req_we) begin
               m_q    = ref_mem[eff];
               m_wait = 1;
            end
         end else if (m_busy) begin
            if (m_wait > 0) m_wait = m_wait - 1;
            else if (resp_ready) m_busy = 1'b0;
         end
      end
   end

   task automatic do_op(input logic we, input logic [4:0] idx, input logic [7:0] d, input int hold,
                        input int exp_lat, input logic [7:0] exp_q, input logic exp_err, input string nm);
      int  lat;
      bit  got;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_idx = idx; req_d = d;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
      end
      if (!got) chk({nm, "_accept_timeout"}, 1, 0);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      resp_ready = (hold == 0);
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         if (i > 0) @(negedge clk);
         else @(negedge clk);
         lat++;
         if (resp_valid) got = 1'b1;
      end
      if (!got) chk({nm, "_resp_timeout"}, 1, 0);
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_q"}, resp_q, exp_q);
      chk({nm, "_err"}, resp_err, exp_err);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_we = 1'b1; req_idx = 5'd0; req_d = 8'hFF;
         @(negedge clk);
         chk({nm, "_stall_valid"}, resp_valid, 1'b1);
         chk({nm, "_stall_q"}, resp_q, exp_q);
         chk({nm, "_stall_ready"}, req_ready, 1'b0);
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         req_valid  = 1'b0;
         resp_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_released"}, req_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_q", resp_q, 8'h00);
      chk("reset_err", resp_err, 1'b0);
      chk("reset_req_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;

      do_op(1'b1, 5'd3,    8'hA5, 0, 1, 8'h00, 1'b0, "wr3");
      do_op(1'b0, 5'd3,    8'h00, 0, 2, 8'hA5, 1'b0, "rd3");
      do_op(1'b1, 5'h1F,   8'h3C, 0, 1, 8'h00, 1'b0, "wr_m1");
      do_op(1'b0, 5'd9,    8'h00, 0, 2, 8'h3C, 1'b0, "rd9");
      do_op(1'b0, 5'h16,   8'h00, 0, 2, 8'h00, 1'b0, "rd_m10");
      do_op(1'b0, 5'h19,   8'h00, 0, 2, 8'hA5, 1'b0, "rd_m7");
      do_op(1'b0, 5'd10,   8'h00, 0, 1, 8'h00, 1'b1, "rd10");
      do_op(1'b1, 5'd10,   8'h11, 0, 1, 8'h00, 1'b1, "wr10");
      do_op(1'b0, 5'h15,   8'h00, 0, 1, 8'h00, 1'b1, "rd_m11");
      do_op(1'b1, 5'h15,   8'h22, 0, 1, 8'h00, 1'b1, "wr_m11");
      do_op(1'b1, 5'h10,   8'h33, 0, 1, 8'h00, 1'b1, "wr_m16");
      do_op(1'b1, 5'h16,   8'h77, 5, 1, 8'h00, 1'b0, "wr_m10_stall");
      do_op(1'b0, 5'd0,    8'h00, 5, 2, 8'h77, 1'b0, "rd0_stall");
      do_op(1'b0, 5'd9,    8'h00, 0, 2, 8'h3C, 1'b0, "rd9_again");

      // Reset asserted while the read sits in CAPTURE.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_idx = 5'd3;
      @(negedge clk);
      chk("rstcap_accept", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstcap_in_capture", req_ready, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("rstcap_resp_valid", resp_valid, 1'b0);
      chk("rstcap_idle", req_ready, 1'b1);
      chk("rstcap_q", resp_q, 8'h00);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("rstcap_no_resp", resp_valid, 1'b0);
      end

      do_op(1'b0, 5'd3, 8'h00, 0, 2, 8'hA5, 1'b0, "rd3_post_rst");

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
